vga_fb_write_buffer: RTL

- Upstream stage of the VGA pixel path; runs on the VGA pixel clock.
- Accepts pixel writes from the processor store path and buffers them in a small FIFO.
- Commits buffered writes to the framebuffer write port only while the sync controller reports blanking, so stores never collide with scan-out reads through the memory map.
- Drops writes outside the 400x400 visible region and flags them.

---
 rtl/vga_fb_write_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_fb_write_buffer.sv
// Pixel write buffer on the VGA pixel clock: holds processor stores and commits them only during blanking.
// Latency: commit no earlier than the second edge after acceptance. Backpressure: wr_ready low while the FIFO is full.

// Generic occupancy-tracked FIFO; level is kept separately so full/empty are unambiguous at wrap.
// Latency: head visible the cycle after push into an empty FIFO. Backpressure: caller must not push when full or pop when empty.
module vga_fb_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_dat,
  output logic [W-1:0]  head_dat,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// Framebuffer write buffer top: range-checks stores, queues them, drains one per cycle while blanking.
// Latency: 2 edges minimum from accept to fb_we. Backpressure: wr_ready = not full, from registered level only.
module vga_fb_write_buffer #(
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 18,
  parameter int DEPTH     = 8,
  parameter int FB_PIXELS = 160000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     vga_blank_n,
  output logic                     fb_we,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [DATA_W-1:0]        fb_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_flag
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t push_ent;
  entry_t head_ent;
  logic   in_range;
  logic   accept;
  logic   push;
  logic   pop;

  assign wr_ready = (level != LW'(DEPTH));
  assign in_range = (32'(wr_addr) < 32'(FB_PIXELS));
  assign accept   = wr_valid & wr_ready;
  assign push     = accept & in_range;
  // Commits only in blanking so stores never race scan-out reads.
  assign pop      = (level != '0) & ~vga_blank_n;

  assign push_ent.addr = wr_addr;
  assign push_ent.data = wr_data;

  vga_fb_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_dat (push_ent),
    .head_dat (head_ent),
    .level    (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= pop;
      if (pop) begin
        fb_addr <= head_ent.addr;
        fb_data <= head_ent.data;
      end
    end
  end

  // Sticky until reset; a rejected (full) request never reaches here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_flag <= 1'b0;
    end else if (accept && !in_range) begin
      drop_flag <= 1'b1;
    end
  end

endmodule
